and_operand_loader: RTL and testbench
=====================================

# and_operand_loader

Upstream operand-capture stage for the 8-bit AND unit. It accepts a byte stream over a valid/ready handshake, pairs consecutive bytes as operand A then operand B, and presents each completed pair to the AND stage through a registered output slot with its own valid/ready handshake. A one-pair output buffer lets the next A byte load while the previous pair waits for the consumer.

## Interface
- WIDTH, 8, operand width in bits; applies to in_data, op_a and op_b.
- CNT_W, 8, width of the issued-pair counter.

- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset; clears all state immediately, independent of clk.
- in_data  input  WIDTH  incoming operand byte.
- in_valid  input  1  in_data is valid this cycle.
- in_sync  input  1  qualifies the current beat as operand A; sampled only on an accepted beat.
- in_ready  output  1  loader accepts the beat this cycle.
- op_a  output  WIDTH  operand A of the issued pair.
- op_b  output  WIDTH  operand B of the issued pair.
- op_valid  output  1  op_a/op_b hold a pair for the AND stage.
- op_ready  input  1  AND stage consumes the pair this cycle.
- pair_count  output  CNT_W  number of pairs consumed since reset.
- busy  output  1  high when an A byte is staged or op_valid is high.

## Operation
- Accepted input beat: in_valid & in_ready. Issued pair: op_valid & op_ready.
- FSM has two states: LOAD_A and LOAD_B. Reset state is LOAD_A.
- LOAD_A:
  - in_ready = 1.
  - An accepted beat writes in_data to the internal a_stage register and moves to LOAD_B.
  - in_sync has no extra effect in this state.
- LOAD_B:
  - in_ready = !op_valid | op_ready. This is a combinational path from op_ready and is permitted.
  - An accepted beat with in_sync = 0 completes the pair: op_a <= a_stage, op_b <= in_data, op_valid <= 1, and the FSM returns to LOAD_A.
  - An accepted beat with in_sync = 1 is a realignment: in_data overwrites a_stage, the FSM stays in LOAD_B, and the output slot is untouched.
  - Realignment is accepted only when in_ready = 1.
- Output slot:
  - op_a and op_b are stable while op_valid = 1 and op_ready = 0.
  - An issued pair with no new pair completing in the same cycle gives op_valid <= 0.
  - An issued pair and a completing pair in the same cycle gives op_valid = 1 with the new operands; there is no bubble.
- pair_count increments by 1 on every issued pair and wraps from 2^CNT_W-1 to 0.
- Outputs never depend on in_data combinationally. op_a, op_b and op_valid are registered.

## Timing
- Reset values: in_ready = 1 (LOAD_A), op_a = 0, op_b = 0, op_valid = 0, pair_count = 0, busy = 0. a_stage = 0.
- Reset asserted mid-pair discards the staged A byte and any pending output pair. The first beat after rst_n deasserts is treated as A.
- Latency: B accepted at edge t gives op_valid high in the cycle after t. The A-to-B beats can be back-to-back.
- Throughput: 1 pair per 2 input beats when op_ready is held high.
- Backpressure: with op_valid = 1 and op_ready = 0, the loader still accepts one A byte. It then holds in_ready = 0 in LOAD_B until op_ready = 1.
- in_valid may drop between A and B for any number of cycles; a_stage holds its value.
- busy is registered-state derived: busy = (state == LOAD_B) | op_valid.

## Test plan
- Reset then stream 0xF0, 0x3C with op_ready = 1 -> one cycle after the B beat, op_valid = 1, op_a = 0xF0, op_b = 0x3C; pair_count = 1 one cycle later.
- op_ready = 0, send 0xAA, 0x55, then 0x11 -> first pair held stable with op_a = 0xAA, op_b = 0x55; 0x11 accepted as A; in_ready = 0 in LOAD_B until op_ready pulses; the next B (0x22) is accepted in the op_ready cycle and the slot reloads to 0x11/0x22 with no bubble.
- Send A = 0x01, then 0x77 with in_sync = 1, then 0x0F -> issued pair is op_a = 0x77, op_b = 0x0F.
- Continuous stream of 512 bytes with op_ready = 1 -> 256 pairs issued, pair_count wraps to 0, each pair matches a scoreboard of consecutive byte pairs.
- Assert rst_n low asynchronously mid-cycle while in LOAD_B with op_valid = 1 -> op_valid, pair_count and busy go to 0 immediately; the next byte after release appears as op_a.
- Random in_valid and op_ready gaps over 10k cycles -> no lost, duplicated or reordered pairs, and op_a/op_b never change while op_valid & !op_ready.

Source files
------------

// File: rtl/and_operand_loader_if.sv
// Operand-loader bus: byte-stream input handshake plus the paired-operand
// output slot and its status.
//   in_data/in_valid/in_sync/in_ready : upstream byte stream (A then B)
//   op_a/op_b/op_valid/op_ready       : issued operand pair to the AND stage
//   pair_count/busy                   : status (pairs consumed, work pending)
// master = producer/consumer side, slave = the loader.
interface and_operand_loader_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_sync;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_valid;
  logic             op_ready;
  logic [CNT_W-1:0] pair_count;
  logic             busy;

  modport master (
    output in_data, in_valid, in_sync, op_ready,
    input  in_ready, op_a, op_b, op_valid, pair_count, busy
  );

  modport slave (
    input  in_data, in_valid, in_sync, op_ready,
    output in_ready, op_a, op_b, op_valid, pair_count, busy
  );
endinterface

// File: rtl/and_operand_loader.sv
// Operand-capture stage for the AND unit. Pairs consecutive accepted bytes
// as operand A then operand B and presents each pair in a registered output
// slot. While a pair waits in the slot, the next A byte can still be staged.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : and_operand_loader_if.slave (input stream, output slot, status)
module and_operand_loader #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input logic                clk,
  input logic                rst_n,
  and_operand_loader_if.slave bus
);

  typedef enum logic {
    LOAD_A = 1'b0,
    LOAD_B = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_stage;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic             op_valid_q;
  logic [CNT_W-1:0] pair_count_q;

  logic in_ready_c;
  logic accept_c;
  logic issue_c;
  logic complete_c;

  // A beat is always taken; a B beat only if the slot is free or draining now.
  assign in_ready_c = (state == LOAD_A) | ~op_valid_q | bus.op_ready;
  assign accept_c   = bus.in_valid & in_ready_c;
  assign issue_c    = op_valid_q & bus.op_ready;
  assign complete_c = accept_c & (state == LOAD_B) & ~bus.in_sync;

  // Pairing FSM, output slot and issued-pair counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= LOAD_A;
      a_stage      <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_valid_q   <= 1'b0;
      pair_count_q <= '0;
    end else begin
      if (issue_c) begin
        pair_count_q <= pair_count_q + CNT_W'(1);
      end

      // A completing pair refills the slot even in the cycle it drains.
      if (complete_c) begin
        op_valid_q <= 1'b1;
      end else if (issue_c) begin
        op_valid_q <= 1'b0;
      end

      case (state)
        LOAD_A: begin
          if (accept_c) begin
            a_stage <= bus.in_data;
            state   <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (accept_c) begin
            if (bus.in_sync) begin
              // Realignment: this beat is a fresh A, slot untouched.
              a_stage <= bus.in_data;
            end else begin
              op_a_q <= a_stage;
              op_b_q <= bus.in_data;
              state  <= LOAD_A;
            end
          end
        end
        default: state <= LOAD_A;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.op_a       = op_a_q;
  assign bus.op_b       = op_b_q;
  assign bus.op_valid   = op_valid_q;
  assign bus.pair_count = pair_count_q;
  assign bus.busy       = (state == LOAD_B) | op_valid_q;

endmodule

// File: tb/tb_and_operand_loader.sv
// Directed and randomized bench for and_operand_loader. Inputs change on the
// falling edge; outputs are sampled 1 time unit later.
module tb_and_operand_loader;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   chk_cnt = 0;
  int   pass_cnt = 0;

  and_operand_loader_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  and_operand_loader #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_sync  = 1'b0;
    bus.in_data  = 8'h00;
  endtask

  task automatic beat(input logic [7:0] d, input logic s);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_sync  = s;
  endtask

  function automatic logic [7:0] byte_at(input int i);
    return 8'((i * 37 + 11) % 256);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus.op_ready = 1'b0;
    idle();
    #3;
    chk_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else pass_cnt++;
    chk_cnt++; if (bus.op_valid !== 1'b0) $display("FAIL reset_op_valid: got %b want 0", bus.op_valid); else pass_cnt++;
    chk_cnt++; if ({bus.op_a, bus.op_b} !== 16'h0000) $display("FAIL reset_operands: got %h%h want 0000", bus.op_a, bus.op_b); else pass_cnt++;
    chk_cnt++; if (bus.pair_count !== 8'd0) $display("FAIL reset_pair_count: got %0d want 0", bus.pair_count); else pass_cnt++;
    chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // in_sync on the A beat must be ignored in LOAD_A.
  task automatic test_basic();
    bus.op_ready = 1'b1;
    beat(8'hF0, 1'b1);
    #1;
    chk_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL basic_ready_a: got %b want 1", bus.in_ready); else pass_cnt++;
    @(negedge clk);
    beat(8'h3C, 1'b0);
    #1;
    chk_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL basic_ready_b: got %b want 1", bus.in_ready); else pass_cnt++;
    @(negedge clk);
    idle();
    #1;
    chk_cnt++; if ({bus.op_valid, bus.op_a, bus.op_b} !== {1'b1, 8'hF0, 8'h3C}) $display("FAIL basic_pair: got v=%b %h/%h want v=1 f0/3c", bus.op_valid, bus.op_a, bus.op_b); else pass_cnt++;
    chk_cnt++; if (bus.pair_count !== 8'd0) $display("FAIL basic_count_before: got %0d want 0", bus.pair_count); else pass_cnt++;
    chk_cnt++; if (bus.busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", bus.busy); else pass_cnt++;
    @(negedge clk);
    #1;
    chk_cnt++; if (bus.pair_count !== 8'd1) $display("FAIL basic_count_after: got %0d want 1", bus.pair_count); else pass_cnt++;
    chk_cnt++; if ({bus.op_valid, bus.busy} !== 2'b00) $display("FAIL basic_drained: got v=%b busy=%b want 0 0", bus.op_valid, bus.busy); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    bus.op_ready = 1'b0;
    beat(8'hAA, 1'b0);
    @(negedge clk);
    beat(8'h55, 1'b0);
    @(negedge clk);
    beat(8'h11, 1'b0);
    #1;
    chk_cnt++; if ({bus.op_valid, bus.op_a, bus.op_b} !== {1'b1, 8'hAA, 8'h55}) $display("FAIL bp_first_pair: got v=%b %h/%h want v=1 aa/55", bus.op_valid, bus.op_a, bus.op_b); else pass_cnt++;
    chk_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL bp_ready_a: got %b want 1", bus.in_ready); else pass_cnt++;
    @(negedge clk);
    beat(8'h22, 1'b0);
    #1;
    chk_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL bp_ready_b_blocked: got %b want 0", bus.in_ready); else pass_cnt++;
    chk_cnt++; if (bus.busy !== 1'b1) $display("FAIL bp_busy: got %b want 1", bus.busy); else pass_cnt++;
    @(negedge clk);
    #1;
    chk_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL bp_ready_still_blocked: got %b want 0", bus.in_ready); else pass_cnt++;
    chk_cnt++; if ({bus.op_valid, bus.op_a, bus.op_b} !== {1'b1, 8'hAA, 8'h55}) $display("FAIL bp_held_stable: got v=%b %h/%h want v=1 aa/55", bus.op_valid, bus.op_a, bus.op_b); else pass_cnt++;
    chk_cnt++; if (bus.pair_count !== 8'd1) $display("FAIL bp_count_held: got %0d want 1", bus.pair_count); else pass_cnt++;
    bus.op_ready = 1'b1;
    #1;
    chk_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL bp_ready_released: got %b want 1", bus.in_ready); else pass_cnt++;
    @(negedge clk);
    bus.op_ready = 1'b0;
    idle();
    #1;
    chk_cnt++; if ({bus.op_valid, bus.op_a, bus.op_b} !== {1'b1, 8'h11, 8'h22}) $display("FAIL bp_reload_no_bubble: got v=%b %h/%h want v=1 11/22", bus.op_valid, bus.op_a, bus.op_b); else pass_cnt++;
    chk_cnt++; if (bus.pair_count !== 8'd2) $display("FAIL bp_count_2: got %0d want 2", bus.pair_count); else pass_cnt++;
    @(negedge clk);
    bus.op_ready = 1'b1;
    @(negedge clk);
    #1;
    chk_cnt++; if ({bus.op_valid, bus.pair_count} !== {1'b0, 8'd3}) $display("FAIL bp_drain: got v=%b cnt=%0d want v=0 cnt=3", bus.op_valid, bus.pair_count); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_realign();
    bus.op_ready = 1'b0;
    beat(8'h01, 1'b0);
    @(negedge clk);
    beat(8'h77, 1'b1);
    #1;
    chk_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL realign_ready: got %b want 1", bus.in_ready); else pass_cnt++;
    @(negedge clk);
    beat(8'h0F, 1'b0);
    #1;
    chk_cnt++; if ({bus.op_valid, bus.busy} !== 2'b01) $display("FAIL realign_slot_untouched: got v=%b busy=%b want v=0 busy=1", bus.op_valid, bus.busy); else pass_cnt++;
    @(negedge clk);
    idle();
    #1;
    chk_cnt++; if ({bus.op_valid, bus.op_a, bus.op_b} !== {1'b1, 8'h77, 8'h0F}) $display("FAIL realign_pair: got v=%b %h/%h want v=1 77/0f", bus.op_valid, bus.op_a, bus.op_b); else pass_cnt++;
    bus.op_ready = 1'b1;
    @(negedge clk);
    #1;
    chk_cnt++; if ({bus.op_valid, bus.pair_count} !== {1'b0, 8'd4}) $display("FAIL realign_drain: got v=%b cnt=%0d want v=0 cnt=4", bus.op_valid, bus.pair_count); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_stream();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.op_ready = 1'b1;
    for (int i = 0; i < 512; i++) begin
      beat(byte_at(i), 1'b0);
      #1;
      if (bus.in_ready !== 1'b1) begin
        chk_cnt++; $display("FAIL stream_ready[%0d]: got %b want 1", i, bus.in_ready);
      end
      @(negedge clk);
      if (i % 2 == 1) begin
        #1;
        chk_cnt++; if ({bus.op_valid, bus.op_a, bus.op_b} !== {1'b1, byte_at(i - 1), byte_at(i)}) $display("FAIL stream_pair[%0d]: got v=%b %h/%h want v=1 %h/%h", i / 2, bus.op_valid, bus.op_a, bus.op_b, byte_at(i - 1), byte_at(i)); else pass_cnt++;
        chk_cnt++; if (bus.pair_count !== 8'((i - 1) / 2)) $display("FAIL stream_count[%0d]: got %0d want %0d", i / 2, bus.pair_count, (i - 1) / 2); else pass_cnt++;
      end
    end
    idle();
    @(negedge clk);
    #1;
    chk_cnt++; if ({bus.op_valid, bus.busy, bus.pair_count} !== {2'b00, 8'd0}) $display("FAIL stream_wrap: got v=%b busy=%b cnt=%0d want 0 0 0", bus.op_valid, bus.busy, bus.pair_count); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    bus.op_ready = 1'b1;
    beat(8'h10, 1'b0);
    @(negedge clk);
    beat(8'h20, 1'b0);
    @(negedge clk);
    beat(8'hC3, 1'b0);
    @(negedge clk);
    bus.op_ready = 1'b0;
    beat(8'h3C, 1'b0);
    @(negedge clk);
    beat(8'h99, 1'b0);
    @(negedge clk);
    idle();
    #1;
    chk_cnt++; if ({bus.op_valid, bus.busy, bus.pair_count} !== {2'b11, 8'd1}) $display("FAIL arst_pre: got v=%b busy=%b cnt=%0d want 1 1 1", bus.op_valid, bus.busy, bus.pair_count); else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    chk_cnt++; if ({bus.op_valid, bus.busy, bus.pair_count} !== {2'b00, 8'd0}) $display("FAIL arst_immediate: got v=%b busy=%b cnt=%0d want 0 0 0", bus.op_valid, bus.busy, bus.pair_count); else pass_cnt++;
    chk_cnt++; if ({bus.in_ready, bus.op_a, bus.op_b} !== {1'b1, 16'h0000}) $display("FAIL arst_slot: got rdy=%b %h/%h want 1 00/00", bus.in_ready, bus.op_a, bus.op_b); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    beat(8'h5E, 1'b0);
    @(negedge clk);
    beat(8'hE5, 1'b0);
    @(negedge clk);
    idle();
    #1;
    chk_cnt++; if ({bus.op_valid, bus.op_a, bus.op_b} !== {1'b1, 8'h5E, 8'hE5}) $display("FAIL arst_first_is_a: got v=%b %h/%h want v=1 5e/e5", bus.op_valid, bus.op_a, bus.op_b); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [15:0] q[$];
    logic        m_b;
    logic [7:0]  m_a;
    logic        held;
    logic [15:0] held_pair;
    logic        exp_valid;
    logic        exp_ready;
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    m_b  = 1'b0;
    m_a  = 8'h00;
    held = 1'b0;
    held_pair = 16'h0000;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      if (held) begin
        chk_cnt++; if ({bus.op_valid, bus.op_a, bus.op_b} !== {1'b1, held_pair}) $display("FAIL rand_stable[%0d]: got v=%b %h%h want v=1 %h", c, bus.op_valid, bus.op_a, bus.op_b, held_pair); else pass_cnt++;
      end
      if (c >= 9980) begin
        bus.op_ready = 1'b1;
        bus.in_valid = 1'b0;
      end else begin
        bus.op_ready = ($urandom_range(0, 1) == 1);
        bus.in_valid = ($urandom_range(0, 2) != 0);
      end
      bus.in_data = 8'($urandom);
      bus.in_sync = ($urandom_range(0, 7) == 0);
      #1;
      exp_valid = (q.size() != 0);
      exp_ready = !m_b || !exp_valid || bus.op_ready;
      chk_cnt++; if (bus.op_valid !== exp_valid) $display("FAIL rand_valid[%0d]: got %b want %b", c, bus.op_valid, exp_valid); else pass_cnt++;
      chk_cnt++; if (bus.in_ready !== exp_ready) $display("FAIL rand_ready[%0d]: got %b want %b", c, bus.in_ready, exp_ready); else pass_cnt++;
      if (exp_valid && bus.op_ready) begin
        chk_cnt++; if ({bus.op_a, bus.op_b} !== q[0]) $display("FAIL rand_pair[%0d]: got %h%h want %h", c, bus.op_a, bus.op_b, q[0]); else pass_cnt++;
        void'(q.pop_front());
        held = 1'b0;
      end else begin
        held = exp_valid;
        if (exp_valid) held_pair = q[0];
      end
      if (bus.in_valid && exp_ready) begin
        if (!m_b) begin
          m_a = bus.in_data;
          m_b = 1'b1;
        end else if (bus.in_sync) begin
          m_a = bus.in_data;
        end else begin
          q.push_back({m_a, bus.in_data});
          m_b = 1'b0;
        end
      end
    end
    @(negedge clk);
    #1;
    chk_cnt++; if ({bus.op_valid, q.size() == 0} !== 2'b01) $display("FAIL rand_drained: got v=%b pending=%0d want v=0 pending=0", bus.op_valid, q.size()); else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.op_ready = 1'b0;
    idle();
    test_reset();
    test_basic();
    test_backpressure();
    test_realign();
    test_stream();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, chk_cnt);
    $fatal(1, "timeout");
  end

endmodule
